cdb_arbiter: RTL

//  Responder side of the req_if CDB request handshake. Execution units (ALU, FPU, lw_sw, ...)

---
 rtl/cdb_arbiter_pkg.sv | 19 +
 rtl/cdb_arbiter_rr_pick.sv | 36 +++
 rtl/cdb_arbiter.sv | 74 +++++++
 3 files changed

// File: rtl/cdb_arbiter_pkg.sv
// Shared CDB definitions: broadcast bus type, ROB tag width and per-file source counts.
package cdb_arbiter_pkg;

  localparam int ROB_WIDTH     = 5;
  localparam int CDB_N_SRC_GPR = 4;
  localparam int CDB_N_SRC_FPR = 3;

  typedef struct packed {
    logic                 valid;
    logic [ROB_WIDTH-1:0] tag;
    logic [31:0]          data;
  } cdb_t;

  // Wakeup test used by reservation stations snooping the bus.
  function automatic logic tag_match(input cdb_t bus, input logic [ROB_WIDTH-1:0] tag);
    return bus.valid && (bus.tag == tag);
  endfunction

endpackage

// File: rtl/cdb_arbiter_rr_pick.sv
// Rotating priority encoder: first set request at or above start, wrapping mod N_SRC.
module cdb_arbiter_rr_pick #(
  parameter int N_SRC = 4,
  parameter int SRC_W = $clog2(N_SRC)
) (
  input  logic [N_SRC-1:0] req,
  input  logic [SRC_W-1:0] start,
  output logic [N_SRC-1:0] gnt_onehot,
  output logic [SRC_W-1:0] gnt_idx,
  output logic             any
);

  logic [SRC_W:0]   w_sum;
  logic [SRC_W-1:0] w_idx;

  // NOTE: every output and temporary gets a default before the loop so no latch is inferred.
  always_comb begin
    gnt_onehot = '0;
    gnt_idx    = '0;
    any        = 1'b0;
    w_sum      = '0;
    w_idx      = '0;
    for (int k = 0; k < N_SRC; k++) begin
      // Explicit wrap instead of modulo keeps non-power-of-two N_SRC cheap.
      w_sum = {1'b0, start} + (SRC_W+1)'(k);
      if (w_sum >= (SRC_W+1)'(N_SRC)) w_sum = w_sum - (SRC_W+1)'(N_SRC);
      w_idx = w_sum[SRC_W-1:0];
      if (!any && req[w_idx]) begin
        any               = 1'b1;
        gnt_onehot[w_idx] = 1'b1;
        gnt_idx           = w_idx;
      end
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin CDB arbiter: grants one execution unit per cycle and broadcasts its
// result on the common data bus exactly one cycle after the handshake.
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int N_SRC = CDB_N_SRC_GPR,
  parameter int SRC_W = $clog2(N_SRC)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_SRC-1:0] req_valid,
  output logic [N_SRC-1:0] req_ready,
  input  cdb_t             src_result [N_SRC],
  input  logic             flush,
  output cdb_t             cdb
);

  logic [SRC_W-1:0] r_rr_ptr;
  logic [SRC_W-1:0] r_sel_q;
  logic             r_pend_q;

  logic [N_SRC-1:0] w_gnt_onehot;
  logic [SRC_W-1:0] w_gnt_idx;
  logic             w_any;
  logic             w_handshake;

  cdb_arbiter_rr_pick #(
    .N_SRC (N_SRC),
    .SRC_W (SRC_W)
  ) u_rr_pick (
    .req        (req_valid),
    .start      (r_rr_ptr),
    .gnt_onehot (w_gnt_onehot),
    .gnt_idx    (w_gnt_idx),
    .any        (w_any)
  );

  // Ready is gated by the async reset itself so no unit sees a grant while in reset.
  assign req_ready   = (reset && !flush) ? w_gnt_onehot : '0;
  assign w_handshake = reset && !flush && w_any;

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rr_ptr <= '0;
      r_sel_q  <= '0;
      r_pend_q <= 1'b0;
    end else begin
      r_pend_q <= w_handshake;
      if (w_handshake) begin
        r_sel_q  <= w_gnt_idx;
        r_rr_ptr <= (w_gnt_idx == SRC_W'(N_SRC - 1)) ? '0 : w_gnt_idx + SRC_W'(1);
      end
    end
  end

  // Tag/data are zeroed when nothing is pending so the bus reads all-zero in reset.
  always_comb begin
    cdb       = '0;
    cdb.valid = r_pend_q && !flush;
    if (r_pend_q) begin
      cdb.tag  = src_result[r_sel_q].tag;
      cdb.data = src_result[r_sel_q].data;
    end
  end

  always @(posedge clk) begin
    if (reset) begin
      assert ($countones(req_ready) <= 1);
      assert ((req_ready & ~req_valid) == '0);
    end
  end

endmodule
